// File: rtl/dff_flop_chain.sv
// dff_flop_chain
//   Reset-conditioning synchroniser built from two primitive cell types.
//   A leading run of async-set flops catches the set pulse, even one that is
//   shorter than a clock period. A trailing run of plain D flops then moves
//   it cleanly into the clk domain. When set is released, SET_VALUE is
//   flushed out of the chain, so q stays at SET_VALUE for at least
//   ASET_STAGES cycles.
//
//   Optional build macro:
//     DFF_FLOP_CHAIN_QN_EN - adds output qn = ~q, taken from the last stage.
//
//   The tap vector holds the chain contents:
//     - slice 0 is d.
//     - slice k is the output of stage k.
//   q is therefore always a flop output. There is no combinational path from
//   d to q.
module dff_flop_chain #(
  parameter int unsigned      WIDTH        = 1,
  parameter int unsigned      ASET_STAGES  = 2,   // legal 1..8
  parameter int unsigned      PLAIN_STAGES = 2,   // legal 0..8
  parameter logic [WIDTH-1:0] SET_VALUE    = {WIDTH{1'b1}}
) (
  input  logic                                       clk,
  input  logic                                       set,
  input  logic [WIDTH-1:0]                           d,
  output logic [WIDTH-1:0]                           q,
`ifdef DFF_FLOP_CHAIN_QN_EN
  output logic [WIDTH-1:0]                           qn,
`endif
  output logic [WIDTH*(ASET_STAGES+PLAIN_STAGES)-1:0] stage_q
);

  localparam int unsigned STAGES = ASET_STAGES + PLAIN_STAGES;

  // Tap vector: slice 0 is the chain input, slice k is stage k's output.
  wire logic [WIDTH*(STAGES+1)-1:0] taps;

  assign taps[0 +: WIDTH] = d;

  // Leading async-set stages. While set is high they are held at SET_VALUE.
  for (genvar k = 0; k < ASET_STAGES; k++) begin : g_aset
    logic [WIDTH-1:0] r;

    // Async-set flop: set forces SET_VALUE at once and wins over a coincident clk edge.
    always_ff @(posedge clk or posedge set) begin
      if (set) begin
        r <= SET_VALUE;
      end else begin
        r <= taps[k*WIDTH +: WIDTH];
      end
    end

    assign taps[(k+1)*WIDTH +: WIDTH] = r;
  end

  // Trailing plain stages. They have no reset, so they pick up SET_VALUE by
  // clocking it out of the last async-set stage.
  for (genvar p = 0; p < PLAIN_STAGES; p++) begin : g_plain
    logic [WIDTH-1:0] r;

    // Plain D flop: captures the previous stage on every rising clk edge.
    always_ff @(posedge clk) begin
      r <= taps[(ASET_STAGES+p)*WIDTH +: WIDTH];
    end

    assign taps[(ASET_STAGES+p+1)*WIDTH +: WIDTH] = r;
  end

  assign stage_q = taps[WIDTH +: WIDTH*STAGES];

  // With PLAIN_STAGES = 0, q is the last async-set flop, so it follows set
  // without a clock edge.
  assign q = taps[STAGES*WIDTH +: WIDTH];

`ifdef DFF_FLOP_CHAIN_QN_EN
  // Complement of q from the same last-stage flop, so it resets to ~SET_VALUE.
  assign qn = ~taps[STAGES*WIDTH +: WIDTH];
`endif

endmodule

// File: tb/tb_dff_flop_chain.sv
// tb_dff_flop_chain
//   Self-checking bench for dff_flop_chain.
//   Main instance: defaults (WIDTH=1, ASET=2, PLAIN=2).
//   Second instance: PLAIN=0, WIDTH=4, SET_VALUE=4'hA.
//
//   Reference model for the main instance, stated as a time-window rule:
//     - act[e] is 1 if set was high at any moment between edges e-1 and e.
//     - d[e] is the d value seen at edge e.
//     - The value entering the plain section at edge j is SET_VALUE if any
//       act in j-A+1..j is 1. Otherwise it is d[j-A].
//     - q after edge e is that value at j = e-P+1.
//   Stimulus only changes set and d mid-period, never on a clock edge.
module tb_dff_flop_chain;

  localparam int A    = 2;
  localparam int P    = 2;
  localparam int MAXE = 1024;

  logic       clk = 1'b0;
  logic       set = 1'b0;
  logic       d   = 1'b0;
  logic       q;
  logic [3:0] stage_q;
`ifdef DFF_FLOP_CHAIN_QN_EN
  logic       qn;
`endif

  logic       set0 = 1'b0;
  logic [3:0] d0   = 4'h0;
  logic [3:0] q0;
  logic [7:0] stage_q0;
`ifdef DFF_FLOP_CHAIN_QN_EN
  logic [3:0] qn0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  dff_flop_chain dut (
    .clk(clk), .set(set), .d(d), .q(q),
`ifdef DFF_FLOP_CHAIN_QN_EN
    .qn(qn),
`endif
    .stage_q(stage_q)
  );

  dff_flop_chain #(.WIDTH(4), .ASET_STAGES(2), .PLAIN_STAGES(0), .SET_VALUE(4'hA)) dut0 (
    .clk(clk), .set(set0), .d(d0), .q(q0),
`ifdef DFF_FLOP_CHAIN_QN_EN
    .qn(qn0),
`endif
    .stage_q(stage_q0)
  );

  // Clock generator: period 10.
  always #5 clk = ~clk;

  // Reference-model bookkeeping.
  int   edge_cnt = 0;
  logic d_hist   [0:MAXE-1];
  bit   act_hist [0:MAXE-1];
  bit   set_flag = 1'b0;

  // Remember any set activity, including glitches between edges.
  always @(posedge set) set_flag = 1'b1;

  // Record the d value and set activity for each edge.
  always @(posedge clk) begin
    if (edge_cnt < MAXE - 1) edge_cnt = edge_cnt + 1;
    d_hist[edge_cnt]   = d;
    act_hist[edge_cnt] = set_flag;
    set_flag           = set;
  end

  // Expected q after edge e, returned as {valid, value}.
  function automatic logic [1:0] model_q(input int e);
    int j;
    j = e - P + 1;
    for (int i = j - A + 1; i <= j; i++) begin
      if (i >= 1 && act_hist[i]) return 2'b11;
    end
    if (j - A >= 1) return {1'b1, d_hist[j-A]};
    return 2'b00;
  endfunction

  task automatic test_reset();
    logic [1:0] exp;
    set = 1'b0;
    d   = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      exp = model_q(edge_cnt);
      if (exp[1]) begin
        n_cmp++;
        if (q !== exp[0]) begin
          n_bad++;
          $display("FAIL powerup_q edge %0d: got %b want %b", edge_cnt, q, exp[0]);
        end
      end
      if (k == 4) begin
        n_cmp++;
        if (q !== 1'b0) begin
          n_bad++;
          $display("FAIL powerup_q_edge4: got %b want 0", q);
        end
        n_cmp++;
        if (stage_q !== 4'b0000) begin
          n_bad++;
          $display("FAIL powerup_stage_q: got %b want 0000", stage_q);
        end
      end
    end
  endtask

  task automatic test_set_stretch();
    logic [1:0] exp;
    d = 1'b0;
    #4 set = 1'b1;
    #1;
    n_cmp++;
    if (stage_q[1:0] !== 2'b11) begin
      n_bad++;
      $display("FAIL set_immediate: got %b want 11", stage_q[1:0]);
    end
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      exp = model_q(edge_cnt);
      n_cmp++;
      if (q !== exp[0]) begin
        n_bad++;
        $display("FAIL stretch_q k=%0d: got %b want %b", k, q, exp[0]);
      end
      if (k == 2) begin
        n_cmp++;
        if (q !== 1'b1) begin
          n_bad++;
          $display("FAIL stretch_q_after2: got %b want 1", q);
        end
`ifdef DFF_FLOP_CHAIN_QN_EN
        n_cmp++;
        if (qn !== 1'b0) begin
          n_bad++;
          $display("FAIL stretch_qn: got %b want 0", qn);
        end
`endif
      end
      if (k == 6) begin
        n_cmp++;
        if (q !== 1'b1) begin
          n_bad++;
          $display("FAIL release_edge3: got %b want 1", q);
        end
      end
      if (k == 7) begin
        n_cmp++;
        if (q !== 1'b0) begin
          n_bad++;
          $display("FAIL release_edge4: got %b want 0", q);
        end
      end
      if (k == 3) #4 set = 1'b0;
    end
  endtask

  task automatic test_glitch();
    logic [1:0] exp;
    int first;
    int count;
    first = 0;
    count = 0;
    d = 1'b0;
    #4 set = 1'b1;
    #2 set = 1'b0;
    for (int g = 1; g <= 5; g++) begin
      @(posedge clk); #1;
      exp = model_q(edge_cnt);
      n_cmp++;
      if (q !== exp[0]) begin
        n_bad++;
        $display("FAIL glitch_q g=%0d: got %b want %b", g, q, exp[0]);
      end
      if (q === 1'b1) begin
        count++;
        if (first == 0) first = g;
      end
    end
    n_cmp++;
    if (first != 2) begin
      n_bad++;
      $display("FAIL glitch_start: got edge %0d want edge 2", first);
    end
    n_cmp++;
    if (count != 2) begin
      n_bad++;
      $display("FAIL glitch_width: got %0d cycles want 2", count);
    end
  endtask

  task automatic test_data();
    logic [1:0] exp;
    logic       seq [0:23];
    seq[0] = 1'b1;
    seq[1] = 1'b0;
    seq[2] = 1'b1;
    seq[3] = 1'b1;
    seq[4] = 1'b0;
    for (int i = 5; i < 24; i++) seq[i] = 1'($urandom_range(0, 1));
    for (int i = 0; i < 24; i++) begin
      #4 d = seq[i];
      @(posedge clk); #1;
      exp = model_q(edge_cnt);
      n_cmp++;
      if (q !== exp[0]) begin
        n_bad++;
        $display("FAIL data_q i=%0d: got %b want %b", i, q, exp[0]);
      end
      if (i >= 3) begin
        n_cmp++;
        if (q !== seq[i-3]) begin
          n_bad++;
          $display("FAIL data_latency i=%0d: got %b want %b", i, q, seq[i-3]);
        end
      end
    end
  endtask

  task automatic test_repulse();
    logic [1:0] exp;
    #4 d = 1'b0;
    set = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      exp = model_q(edge_cnt);
      n_cmp++;
      if (q !== exp[0]) begin
        n_bad++;
        $display("FAIL repulse_q k=%0d: got %b want %b", k, q, exp[0]);
      end
      if (k == 6 || k == 7) begin
        n_cmp++;
        if (q !== 1'b1) begin
          n_bad++;
          $display("FAIL repulse_deferred k=%0d: got %b want 1", k, q);
        end
      end
      if (k == 8) begin
        n_cmp++;
        if (q !== 1'b0) begin
          n_bad++;
          $display("FAIL repulse_release: got %b want 0", q);
        end
      end
      if (k == 2) #4 set = 1'b0;
      if (k == 3) #4 set = 1'b1;
      if (k == 4) #4 set = 1'b0;
    end
  endtask

  task automatic test_random();
    logic [1:0] exp;
    int r;
    for (int n = 0; n < 300; n++) begin
      #4 d = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 9);
      if (set) begin
        if (r < 3) set = 1'b0;
      end else if (r == 0) begin
        set = 1'b1;
      end else if (r == 1) begin
        set = 1'b1;
        #2 set = 1'b0;
      end
      @(posedge clk); #1;
      exp = model_q(edge_cnt);
      if (exp[1]) begin
        n_cmp++;
        if (q !== exp[0]) begin
          n_bad++;
          $display("FAIL random_q n=%0d: got %b want %b", n, q, exp[0]);
        end
      end
    end
    #4 set = 1'b0;
  endtask

  task automatic test_plain0();
    #4 d0 = 4'h3;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (q0 !== 4'h3) begin
      n_bad++;
      $display("FAIL p0_data: got %h want 3", q0);
    end
    #4 set0 = 1'b1;
    #1;
    n_cmp++;
    if (q0 !== 4'hA) begin
      n_bad++;
      $display("FAIL p0_set_noclk: got %h want a", q0);
    end
    n_cmp++;
    if (stage_q0 !== 8'hAA) begin
      n_bad++;
      $display("FAIL p0_stage_q: got %h want aa", stage_q0);
    end
`ifdef DFF_FLOP_CHAIN_QN_EN
    n_cmp++;
    if (qn0 !== 4'h5) begin
      n_bad++;
      $display("FAIL p0_qn: got %h want 5", qn0);
    end
`endif
    @(posedge clk); #1;
    n_cmp++;
    if (q0 !== 4'hA) begin
      n_bad++;
      $display("FAIL p0_hold: got %h want a", q0);
    end
    #4 d0 = 4'h6;
    set0 = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (stage_q0 !== 8'hA6) begin
      n_bad++;
      $display("FAIL p0_release1: got %h want a6", stage_q0);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (q0 !== 4'h6) begin
      n_bad++;
      $display("FAIL p0_release2: got %h want 6", q0);
    end
`ifdef DFF_FLOP_CHAIN_QN_EN
    n_cmp++;
    if (qn0 !== 4'h9) begin
      n_bad++;
      $display("FAIL p0_qn_release: got %h want 9", qn0);
    end
`endif
  endtask

  // Scenario sequence and summary.
  initial begin
    test_reset();
    test_set_stretch();
    test_glitch();
    test_data();
    test_repulse();
    test_random();
    test_plain0();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
